// File: rtl/hw_irq_controller.sv
// Vectored interrupt controller: synchronised edge-latched channels, fixed lowest-index priority, REQ/ack/done handshake.
// Optional input debounce is compiled in when the macro IRQ_DEBOUNCE_EN is defined.
module hw_irq_controller #(
  parameter int              NUM_IRQ    = 8,
  parameter int              VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE  = 16'h0040,
  parameter int              VEC_STRIDE = 4,
  parameter int              DEB_CYCLES = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_IRQ-1:0]         hardware,
  input  logic [NUM_IRQ-1:0]         mask,
  input  logic                       global_en,
  input  logic                       irq_ack,
  input  logic                       irq_done,
  output logic                       irq_req,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  output logic [VEC_W-1:0]           irq_vec,
  output logic                       in_service,
  output logic [NUM_IRQ-1:0]         pending
);

  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_level;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_win;
  logic               w_any;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= hardware;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [NUM_IRQ-1:0] r_deb;
  logic [CNT_W-1:0]   r_cnt [NUM_IRQ];

  // The accepted level only follows the synchronised input after DEB_CYCLES differing samples in a row.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb <= '0;
      for (int i = 0; i < NUM_IRQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_level = r_deb;
`else
  // DEB_CYCLES only has an effect when debounce is compiled in.
  logic [31:0] w_unused_deb;
  assign w_unused_deb = 32'(DEB_CYCLES);
  assign w_level      = r_sync2;
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_elig = r_pending & mask;

  always_comb begin
    w_win = '0;
    w_any = |w_elig;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (global_en && w_any) w_next = S_REQ;
      S_REQ:     if (irq_ack)            w_next = S_SERVICE;
      S_SERVICE: if (irq_done)           w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_comb begin
    irq_req    = 1'b0;
    in_service = 1'b0;
    w_clr      = '0;
    case (r_state)
      S_REQ: begin
        irq_req = 1'b1;
        if (irq_ack) w_clr = NUM_IRQ'(1) << r_id;
      end
      S_SERVICE: in_service = 1'b1;
      default: ;
    endcase
  end

  // Set takes precedence over the ack-clear so an edge arriving with the ack is not lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_id      <= '0;
    end else begin
      r_prev    <= w_level;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (r_state == S_IDLE && w_next == S_REQ) r_id <= w_win;
    end
  end

  assign pending = r_pending;
  assign irq_id  = r_id;
  assign irq_vec = VEC_BASE + VEC_W'(r_id) * VEC_W'(VEC_STRIDE);

endmodule

// File: tb/tb_hw_irq_controller.sv
// Bench for hw_irq_controller: directed scenarios followed by random traffic, all checked against a cycle model.
module tb_hw_irq_controller;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] hardware = 8'h00;
  logic [7:0] mask = 8'hFF;
  logic       global_en = 1'b1;
  logic       irq_ack = 1'b0;
  logic       irq_done = 1'b0;
  logic       irq_req;
  logic [2:0] irq_id;
  logic [15:0] irq_vec;
  logic       in_service;
  logic [7:0] pending;

  hw_irq_controller #(
    .NUM_IRQ(8), .VEC_W(16), .VEC_BASE(16'h0040), .VEC_STRIDE(4), .DEB_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .hardware(hardware), .mask(mask), .global_en(global_en),
    .irq_ack(irq_ack), .irq_done(irq_done), .irq_req(irq_req), .irq_id(irq_id),
    .irq_vec(irq_vec), .in_service(in_service), .pending(pending)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = idle, 1 = requesting, 2 = in service.
  int         m_mode;
  int         m_id;
  logic [7:0] m_pend;
  logic [7:0] hq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_id   = 0;
    m_pend = 8'h00;
    hq     = {8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  // An input rising edge sampled two clocks ago becomes a pending flag now.
  task automatic model_edge();
    logic [7:0] rise;
    logic [7:0] elig;
    logic [7:0] clr;
    int nmode;
    hq.push_front(hardware);
    rise = hq[2] & ~hq[3];
    void'(hq.pop_back());
    elig  = m_pend & mask;
    clr   = 8'h00;
    nmode = m_mode;
    if (m_mode == 0) begin
      if (global_en && elig != 8'h00) begin
        nmode = 1;
        for (int i = 0; i < 8; i++) begin
          if (elig[i]) begin
            m_id = i;
            break;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (irq_ack) begin
        nmode = 2;
        clr[m_id] = 1'b1;
      end
    end else begin
      if (irq_done) nmode = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_mode = nmode;
  endtask

  task automatic check_all();
    chk("irq_req",    32'(irq_req),    32'(m_mode == 1));
    chk("in_service", 32'(in_service), 32'(m_mode == 2));
    chk("irq_id",     32'(irq_id),     32'(m_id));
    chk("irq_vec",    32'(irq_vec),    32'(16'h0040 + m_id * 4));
    chk("pending",    32'(pending),    32'(m_pend));
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [7:0] v);
    hardware = v;
    step();
    hardware = 8'h00;
    step();
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_req",  32'(irq_req),    32'(0));
    chk("rst_svc",  32'(in_service), 32'(0));
    chk("rst_id",   32'(irq_id),     32'(0));
    chk("rst_vec",  32'(irq_vec),    32'h0040);
    chk("rst_pend", 32'(pending),    32'(0));
    steps(2);
    RST_N = 1'b1;
    steps(2);

    // Single pulse on channel 1
    pulse(8'h02);
    step();
    chk("p1_pend_k2", 32'(pending), 32'h02);
    chk("p1_req_k2",  32'(irq_req), 32'(0));
    step();
    chk("p1_req_k3",  32'(irq_req), 32'(1));
    chk("p1_id",      32'(irq_id),  32'(1));
    chk("p1_vec",     32'(irq_vec), 32'h0044);
    do_ack();
    chk("p1_pend_ack", 32'(pending),    32'(0));
    chk("p1_svc",      32'(in_service), 32'(1));
    chk("p1_req_ack",  32'(irq_req),    32'(0));
    do_done();
    chk("p1_svc_done", 32'(in_service), 32'(0));

    // Edge landing on the same clock as its ack-clear
    pulse(8'h02);
    steps(2);
    chk("co_req", 32'(irq_req), 32'(1));
    hardware = 8'h02;
    step();
    hardware = 8'h00;
    step();
    do_ack();
    chk("co_pend", 32'(pending),    32'h02);
    chk("co_svc",  32'(in_service), 32'(1));
    do_done();
    step();
    chk("co_rereq", 32'(irq_req), 32'(1));
    chk("co_id",    32'(irq_id),  32'(1));
    do_ack();
    do_done();

    // Simultaneous edges on channels 1 and 4
    pulse(8'h12);
    steps(2);
    chk("sim_id1",  32'(irq_id),  32'(1));
    chk("sim_vec1", 32'(irq_vec), 32'h0044);
    do_ack();
    do_done();
    chk("sim_idle", 32'(irq_req), 32'(0));
    step();
    chk("sim_req4", 32'(irq_req), 32'(1));
    chk("sim_id4",  32'(irq_id),  32'(4));
    chk("sim_vec4", 32'(irq_vec), 32'h0050);
    do_ack();
    do_done();

    // Masked channel stays pending until unmasked
    mask = 8'hEF;
    pulse(8'h10);
    steps(3);
    chk("msk_pend", 32'(pending), 32'h10);
    chk("msk_req",  32'(irq_req), 32'(0));
    mask = 8'hFF;
    step();
    chk("msk_req_on", 32'(irq_req), 32'(1));
    chk("msk_id",     32'(irq_id),  32'(4));
    do_ack();
    do_done();

    // Re-trigger of the channel being serviced
    pulse(8'h02);
    steps(2);
    do_ack();
    pulse(8'h02);
    steps(2);
    chk("rt_pend", 32'(pending),    32'h02);
    chk("rt_svc",  32'(in_service), 32'(1));
    do_done();
    step();
    chk("rt_req", 32'(irq_req), 32'(1));
    chk("rt_id",  32'(irq_id),  32'(1));
    do_ack();
    do_done();

    // Reset in the middle of a service with channel 3 pending
    pulse(8'h02);
    steps(2);
    do_ack();
    pulse(8'h08);
    steps(2);
    chk("mr_pend", 32'(pending),    32'h08);
    chk("mr_svc",  32'(in_service), 32'(1));
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("mr_req",   32'(irq_req),    32'(0));
    chk("mr_svc0",  32'(in_service), 32'(0));
    chk("mr_id",    32'(irq_id),     32'(0));
    chk("mr_vec",   32'(irq_vec),    32'h0040);
    chk("mr_pend0", 32'(pending),    32'(0));
    step();
    RST_N = 1'b1;
    steps(2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      hardware  = hardware ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(15) == 0) mask = 8'($urandom);
      global_en = ($urandom_range(7) != 0);
      irq_ack   = ($urandom_range(2) == 0);
      irq_done  = ($urandom_range(3) == 0);
      step();
    end
    irq_ack  = 1'b0;
    irq_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
